// File: rtl/serial_alu_sequencer_pkg.sv
// Shared ALU definitions: alu_ctl codes, sequencer state encoding and the
// alu_ctl -> 1-bit slice control decode used by the sequencer and ALU control.
package serial_alu_sequencer_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] OP_AND = 2'd0;
  localparam logic [1:0] OP_OR  = 2'd1;
  localparam logic [1:0] OP_ADD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic       arith;
    logic       slt;
    logic       ainvert;
    logic       binvert;
    logic       carryin;
    logic [1:0] op;
  } slice_ctl_t;

  function automatic logic legal_code(input logic [3:0] code);
    logic ok;
    ok = 1'b0;
    case (code)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_NOR, ALU_SLT: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic slice_ctl_t decode_ctl(input logic [3:0] code);
    slice_ctl_t c;
    c = '0;
    case (code)
      ALU_AND: c.op = OP_AND;
      ALU_OR:  c.op = OP_OR;
      ALU_ADD: begin
        c.op    = OP_ADD;
        c.arith = 1'b1;
      end
      ALU_SUB: begin
        c.binvert = 1'b1;
        c.carryin = 1'b1;
        c.op      = OP_ADD;
        c.arith   = 1'b1;
      end
      ALU_NOR: begin
        c.ainvert = 1'b1;
        c.binvert = 1'b1;
        c.op      = OP_AND;
      end
      ALU_SLT: begin
        c.binvert = 1'b1;
        c.carryin = 1'b1;
        c.op      = OP_ADD;
        c.arith   = 1'b1;
        c.slt     = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/serial_alu_sequencer_slice.sv
// 1-bit ALU slice: optional operand inversion, then AND / OR / full-add.
module my1BitALUv2
  import serial_alu_sequencer_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       ainvert,
  input  logic       binvert,
  input  logic       carryin,
  input  logic [1:0] op,
  output logic       result,
  output logic       carryout
);

  logic aa, bb;

  assign aa       = a ^ ainvert;
  assign bb       = b ^ binvert;
  assign carryout = (aa & bb) | (aa & carryin) | (bb & carryin);

  always_comb begin
    result = aa ^ bb ^ carryin;
    case (op)
      OP_AND:  result = aa & bb;
      OP_OR:   result = aa | bb;
      default: result = aa ^ bb ^ carryin;
    endcase
  end

endmodule

// File: rtl/serial_alu_sequencer.sv
// Bit-serial ALU sequencer: one 1-bit slice walks the operands LSB-first,
// one bit per clock, and publishes result and flags on completion.
//   state   | meaning
//   ST_IDLE | waiting for start; result and flags hold
//   ST_RUN  | one operand bit per cycle through the slice
//   ST_DONE | result valid, done high for this cycle only
module serial_alu_sequencer
  import serial_alu_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_ctl,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow,
  output logic             illegal
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int IW = $clog2(WIDTH);

  state_t           state, state_nxt;
  slice_ctl_t       dec, ctl;
  logic             dec_legal;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-2:0] acc;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    idx;
  logic             carry, slice_cin, slice_res, slice_cout, last_bit, ovf_raw;
  logic [WIDTH-1:0] shifted, final_res;

  assign dec       = decode_ctl(alu_ctl);
  assign dec_legal = legal_code(alu_ctl);
  assign idx       = cnt[IW-1:0];
  assign last_bit  = (cnt == CW'(WIDTH - 1));
  assign slice_cin = (cnt == '0) ? ctl.carryin : carry;

  my1BitALUv2 u_slice (
    .a        (op_a[idx]),
    .b        (op_b[idx]),
    .ainvert  (ctl.ainvert),
    .binvert  (ctl.binvert),
    .carryin  (slice_cin),
    .op       (ctl.op),
    .result   (slice_res),
    .carryout (slice_cout)
  );

  // On the last bit, slice_cin is the carry into the MSB.
  assign ovf_raw   = slice_cin ^ slice_cout;
  assign shifted   = {slice_res, acc};
  assign final_res = ctl.slt ? {{(WIDTH-1){1'b0}}, slice_res ^ ovf_raw} : shifted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = dec_legal ? ST_RUN : ST_DONE;
      ST_RUN:  if (last_bit) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a      <= '0;
      op_b      <= '0;
      ctl       <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      acc       <= '0;
      result    <= '0;
      zero      <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      if (dec_legal) begin
        op_a <= a;
        op_b <= b;
        ctl  <= dec;
        cnt  <= '0;
      end else begin
        result    <= '0;
        zero      <= 1'b1;
        carry_out <= 1'b0;
        overflow  <= 1'b0;
        illegal   <= 1'b1;
      end
    end else if (state == ST_RUN) begin
      acc   <= shifted[WIDTH-1:1];
      carry <= slice_cout;
      cnt   <= cnt + CW'(1);
      if (last_bit) begin
        result    <= final_res;
        zero      <= (final_res == '0);
        carry_out <= ctl.arith & ~ctl.slt & slice_cout;
        overflow  <= ctl.arith & ~ctl.slt & ovf_raw;
        illegal   <= 1'b0;
      end
    end
  end

endmodule

// File: doc/serial_alu_sequencer.md
SERIAL_ALU_SEQUENCER -- requirements
Module: serial_alu_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and result width in bits (minimum 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-005 SHALL have port a, input, WIDTH bits: operand A, captured when start is accepted.
REQ-006 SHALL have port b, input, WIDTH bits: operand B, captured when start is accepted.
REQ-007 SHALL have port alu_ctl, input, 4 bits: operation select, captured when start is accepted.
REQ-008 SHALL have port busy, output, 1 bit: high in RUN and DONE.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-010 SHALL have port result, output, WIDTH bits: final result.
REQ-011 SHALL have ports zero, carry_out, overflow and illegal, outputs, 1 bit each: status flags.

Function
REQ-012 SHALL decode alu_ctl to 1-bit-slice controls {ainvert, binvert, carryIn, op} as follows:
- 0000 AND: {0,0,0,0}
- 0001 OR: {0,0,0,1}
- 0010 ADD: {0,0,0,2}
- 0110 SUB: {0,1,1,2}
- 1100 NOR: {1,1,0,0}
- 0111 SLT: {0,1,1,2}
REQ-013 SHALL treat any other alu_ctl code as illegal: no RUN phase, result=0, illegal=1, done pulses on the next edge.
REQ-014 SHALL implement the FSM states IDLE, RUN and DONE; reset state is IDLE.
REQ-015 SHALL accept start only in IDLE; start while busy SHALL be ignored and SHALL leave the registered operands unchanged.
REQ-016 SHALL, in IDLE with start=1 and a legal code: capture a, b and the decoded controls at edge E0, clear the bit counter and go to RUN.
REQ-017 SHALL, in RUN, present bit i of the captured A and B and the registered carry to one slice instance, with carry = decoded carryIn for i=0.
REQ-018 SHALL, at edges E1..E_WIDTH, shift the slice result into the result register LSB-first and register the slice carryOut.
REQ-019 SHALL go from RUN to DONE at edge E_WIDTH, with done=1 for exactly one cycle, then return to IDLE at edge E_WIDTH+1.
REQ-020 SHALL compute overflow (ADD/SUB/SLT only; else 0) as the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-021 SHALL set carry_out to the carry out of bit WIDTH-1 for ADD/SUB/SLT and to 0 for the logic operations.
REQ-022 SHALL, for SLT, set the final result to {WIDTH-1 zeros, diff[WIDTH-1] XOR overflow}, with overflow and carry_out forced to 0.
REQ-023 SHALL set zero=1 when the final result == 0.
REQ-024 SHALL hold result and all flags stable from done until the next accepted start; they SHALL update only at the DONE transition.
REQ-025 SHALL allow start asserted in the DONE cycle to be ignored; a new start is accepted in IDLE, giving a minimum issue interval of WIDTH+2 cycles.

Reset
REQ-026 SHALL, on rst_n low, immediately drive the FSM to IDLE and busy, done, result, zero, carry_out, overflow, illegal and the internal counter, carry and operand registers to 0.
REQ-027 SHALL, on reset mid-RUN, abandon the operation and produce no done pulse; after rst_n rises, the first start is handled normally.

Structure
REQ-028 SHALL take the alu_ctl code constants, the state encoding and the slice-control decode table from a shared ALU package that also serves the ALU-control block.
REQ-029 SHALL instantiate exactly one existing 1-bit ALU slice (my1BitALUv2) as its only sub-module; no other arithmetic logic SHALL be added.
REQ-030 SHALL hold the bit counter at $clog2(WIDTH)+1 bits.

Verification (WIDTH=8)
REQ-031 Bench SHALL check ADD 0x7F+0x01 -> result 0x80, overflow=1, carry_out=0, zero=0, done at edge E9 only.
REQ-032 Bench SHALL check SUB 0x05-0x05 -> result 0x00, zero=1, carry_out=1, overflow=0.
REQ-033 Bench SHALL check NOR 0xF0,0x0F -> 0x00 with zero=1, and SLT 0x80,0x01 -> 0x01.
REQ-034 Bench SHALL check illegal alu_ctl 1111 -> illegal=1, result=0x00, done one cycle after start.
REQ-035 Bench SHALL check start re-asserted with new operands during RUN -> ignored, with the original ADD 0x03+0x04 giving 0x07.
REQ-036 Bench SHALL check rst_n low at edge E4 of an ADD -> all outputs 0 immediately, no done pulse, and a following ADD 0x01+0x01 giving 0x02.
